// File: rtl/psfp_gate_scheduler_if.sv
// Stream-gate scheduler bus: GCL config, schedule status and per-frame gate query.
// slave = scheduler side, master = software/ingress-pipeline side.
interface psfp_gate_scheduler_if #(
    parameter int NUM_GATES  = 8,
    parameter int GCL_DEPTH  = 16,
    parameter int INTERVAL_W = 32
) ();
    localparam int AW = $clog2(GCL_DEPTH);

    logic                  enable;
    logic                  cfg_wr_en;
    logic [AW-1:0]         cfg_wr_addr;
    logic [NUM_GATES-1:0]  cfg_wr_states;
    logic [INTERVAL_W-1:0] cfg_wr_interval;
    logic [AW:0]           cfg_list_len;
    logic                  cfg_commit;
    logic                  cfg_pending;
    logic [NUM_GATES-1:0]  gate_states;
    logic [AW-1:0]         gcl_index;
    logic                  cycle_start;
    logic                  query_valid;
    logic [11:0]           gate_id_in;
    logic                  gate_open;
    logic                  gate_open_valid;

    modport slave (
        input  enable, cfg_wr_en, cfg_wr_addr, cfg_wr_states, cfg_wr_interval,
               cfg_list_len, cfg_commit, query_valid, gate_id_in,
        output cfg_pending, gate_states, gcl_index, cycle_start, gate_open, gate_open_valid
    );

    modport master (
        output enable, cfg_wr_en, cfg_wr_addr, cfg_wr_states, cfg_wr_interval,
               cfg_list_len, cfg_commit, query_valid, gate_id_in,
        input  cfg_pending, gate_states, gcl_index, cycle_start, gate_open, gate_open_valid
    );
endinterface

// File: rtl/psfp_gate_scheduler.sv
// 802.1Qci stream-gate scheduler with double-buffered GCL; gate query answered 1 cycle later.
// No backpressure: config writes, commits and queries are accepted every cycle.
module psfp_gate_scheduler #(
    parameter int NUM_GATES  = 8,
    parameter int GCL_DEPTH  = 16,
    parameter int INTERVAL_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    psfp_gate_scheduler_if.slave bus
);
    localparam int AW = $clog2(GCL_DEPTH);
    localparam int GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  bank_q, bank_d;
    logic [AW:0]           active_len_q, active_len_d;
    logic [AW:0]           shadow_len_q, shadow_len_d;
    logic                  pending_q, pending_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [INTERVAL_W-1:0] cnt_q, cnt_d;
    logic [NUM_GATES-1:0]  gates_q, gates_d;
    logic                  cs_q, cs_d;
    logic                  go_q, go_d;
    logic                  gov_q, gov_d;

    // Both banks in one array, addressed {bank, entry}; bank_q selects the active one.
    logic [NUM_GATES-1:0]  states_mem [0:(2<<AW)-1];
    logic [INTERVAL_W-1:0] intv_mem   [0:(2<<AW)-1];

    logic                  last;
    logic                  swap_bank;
    logic [AW:0]           ld_addr;
    logic [NUM_GATES-1:0]  ld_states;
    logic [INTERVAL_W-1:0] ld_intv;
    logic [INTERVAL_W-1:0] ld_cnt;
    logic                  wr_bank;

    assign last      = ({1'b0, idx_q} == (active_len_q - 1'b1));
    assign swap_bank = (state_q == RUN) && last && pending_q;
    assign ld_addr   = ((state_q == RUN) && !last) ? {bank_q, idx_q + 1'b1}
                                                   : {bank_q ^ swap_bank, {AW{1'b0}}};
    assign ld_states = states_mem[ld_addr];
    assign ld_intv   = intv_mem[ld_addr];
    // Interval 0 is treated as 1: the counter holds the remaining cycles minus one.
    assign ld_cnt    = (ld_intv == '0) ? '0 : ld_intv - 1'b1;
    assign wr_bank   = ~bank_d;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        active_len_d = active_len_q;
        shadow_len_d = shadow_len_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        gates_d      = gates_q;
        cs_d         = 1'b0;

        case (state_q)
            IDLE: begin
                gates_d = '0;
                idx_d   = '0;
                cnt_d   = '0;
                if (pending_q) begin
                    bank_d       = ~bank_q;
                    active_len_d = shadow_len_q;
                    pending_d    = 1'b0;
                end else if (bus.enable && (active_len_q != '0)) begin
                    state_d = RUN;
                    gates_d = ld_states;
                    cnt_d   = ld_cnt;
                    cs_d    = 1'b1;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                    gates_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!last) begin
                    idx_d   = idx_q + 1'b1;
                    gates_d = ld_states;
                    cnt_d   = ld_cnt;
                end else begin
                    idx_d = '0;
                    if (pending_q) begin
                        bank_d       = ~bank_q;
                        active_len_d = shadow_len_q;
                        pending_d    = 1'b0;
                    end
                    if (pending_q && (shadow_len_q == '0)) begin
                        state_d = IDLE;
                        gates_d = '0;
                        cnt_d   = '0;
                    end else begin
                        gates_d = ld_states;
                        cnt_d   = ld_cnt;
                        cs_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A commit on the swap edge stays pending for the next swap.
        if (bus.cfg_commit) begin
            shadow_len_d = (bus.cfg_list_len > (AW+1)'(GCL_DEPTH)) ? (AW+1)'(GCL_DEPTH)
                                                                   : bus.cfg_list_len;
            pending_d    = 1'b1;
        end
    end

    always_comb begin
        gov_d = bus.query_valid;
        go_d  = bus.query_valid && (bus.gate_id_in < 12'(NUM_GATES)) &&
                gates_q[bus.gate_id_in[GW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            active_len_q <= '0;
            shadow_len_q <= '0;
            pending_q    <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            gates_q      <= '0;
            cs_q         <= 1'b0;
            go_q         <= 1'b0;
            gov_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            active_len_q <= active_len_d;
            shadow_len_q <= shadow_len_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            gates_q      <= gates_d;
            cs_q         <= cs_d;
            go_q         <= go_d;
            gov_q        <= gov_d;
        end
    end

    // Writes land in whichever bank is shadow after this edge's possible swap.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en) begin
            states_mem[{wr_bank, bus.cfg_wr_addr}] <= bus.cfg_wr_states;
            intv_mem[{wr_bank, bus.cfg_wr_addr}]   <= bus.cfg_wr_interval;
        end
    end

    assign bus.cfg_pending     = pending_q;
    assign bus.gate_states     = gates_q;
    assign bus.gcl_index       = idx_q;
    assign bus.cycle_start     = cs_q;
    assign bus.gate_open       = go_q;
    assign bus.gate_open_valid = gov_q;
endmodule
